// File: rtl/world_time_counter_if.sv
// Control inputs and time outputs of world_time_counter. The DUT uses the slave modport.
// The master modport is for whatever drives the buttons/run/tz and reads the time.
interface world_time_counter_if;
  logic       run;
  logic       mode_btn;
  logic       inc_btn;
  logic [4:0] tz_offset;
  logic [6:0] hours;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic [6:0] local_hours;
  logic       sec_tick;
  logic       day_wrap;
  logic [1:0] edit_state;

  modport master (
    output run, mode_btn, inc_btn, tz_offset,
    input  hours, minutes, seconds, local_hours, sec_tick, day_wrap, edit_state
  );

  modport slave (
    input  run, mode_btn, inc_btn, tz_offset,
    output hours, minutes, seconds, local_hours, sec_tick, day_wrap, edit_state
  );
endinterface

// File: rtl/world_time_counter.sv
// HH:MM:SS clock with RUN/SET_HR/SET_MIN edit FSM; WORLD_TIME_TZ_EN adds a clamped time-zone offset on local_hours.
// Latency: time/state/pulses registered (button edge acts 2 edges after rise); no backpressure.
module world_time_counter #(
  parameter int TICKS_PER_SEC = 100
) (
  input logic                 hz100,
  input logic                 reset_n,
  world_time_counter_if.slave tif
);

  typedef struct packed {
    logic [6:0] hh;
    logic [6:0] mm;
    logic [6:0] ss;
  } hms_t;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;
  localparam logic [9:0] PRESC_MAX  = 10'(TICKS_PER_SEC - 1);

  logic [1:0] state, state_nxt;
  hms_t       tm, tm_nxt;
  logic [9:0] presc, presc_nxt;
  logic       hist_vld, mode_q, inc_q, mode_edge, inc_edge;
  logic       sec_tick_q, day_wrap_q;
  logic       counting, wrap, inc_act;
  logic       sec_last, min_last, hr_last;
  logic [6:0] local_h;

  // hist_vld masks the first sampled edge so a button held through reset never fires.
  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      hist_vld  <= 1'b0;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      mode_edge <= 1'b0;
      inc_edge  <= 1'b0;
    end else begin
      hist_vld  <= 1'b1;
      mode_q    <= tif.mode_btn;
      inc_q     <= tif.inc_btn;
      mode_edge <= hist_vld & tif.mode_btn & ~mode_q;
      inc_edge  <= hist_vld & tif.inc_btn & ~inc_q;
    end
  end

  assign counting = (state == ST_RUN) && tif.run;
  assign wrap     = counting && (presc == PRESC_MAX);
  assign inc_act  = inc_edge & ~mode_edge;
  assign sec_last = (tm.ss == 7'd59);
  assign min_last = (tm.mm == 7'd59);
  assign hr_last  = (tm.hh == 7'd23);

  always_comb begin
    state_nxt = state;
    if (mode_edge) begin
      case (state)
        ST_RUN:    state_nxt = ST_SET_HR;
        ST_SET_HR: state_nxt = ST_SET_MIN;
        default:   state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    tm_nxt    = tm;
    presc_nxt = presc;
    if (counting) begin
      presc_nxt = wrap ? 10'd0 : presc + 10'd1;
    end
    if (wrap) begin
      tm_nxt.ss = sec_last ? 7'd0 : tm.ss + 7'd1;
      if (sec_last) begin
        tm_nxt.mm = min_last ? 7'd0 : tm.mm + 7'd1;
        if (min_last) begin
          tm_nxt.hh = hr_last ? 7'd0 : tm.hh + 7'd1;
        end
      end
    end
    // Manual edits never carry; wrap is always 0 outside RUN so these cannot collide.
    if (inc_act && (state == ST_SET_HR)) begin
      tm_nxt.hh = hr_last ? 7'd0 : tm.hh + 7'd1;
    end
    if (inc_act && (state == ST_SET_MIN)) begin
      tm_nxt.mm = min_last ? 7'd0 : tm.mm + 7'd1;
    end
    if (mode_edge && (state == ST_SET_MIN)) begin
      tm_nxt.ss = 7'd0;
      presc_nxt = 10'd0;
    end
  end

  always_ff @(posedge hz100 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      tm         <= '0;
      presc      <= 10'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      tm         <= tm_nxt;
      presc      <= presc_nxt;
      sec_tick_q <= wrap;
      day_wrap_q <= wrap & sec_last & min_last & hr_last;
    end
  end

`ifdef WORLD_TIME_TZ_EN
  logic signed [4:0] tz_s;
  logic        [6:0] tz_bias;
  logic        [6:0] lh_sum;

  // Bias is clamp(tz)+24, always 12..38, so hh+bias stays 12..61 and two conditional subtracts give mod 24.
  always_comb begin
    tz_s = tif.tz_offset;
    if (tz_s < -5'sd12) begin
      tz_bias = 7'd12;
    end else if (tz_s > 5'sd14) begin
      tz_bias = 7'd38;
    end else begin
      tz_bias = 7'(7'sd24 + 7'(tz_s));
    end
    lh_sum = tm.hh + tz_bias;
    if (lh_sum >= 7'd48) begin
      local_h = lh_sum - 7'd48;
    end else if (lh_sum >= 7'd24) begin
      local_h = lh_sum - 7'd24;
    end else begin
      local_h = lh_sum;
    end
  end
`else
  logic tz_unused;
  assign tz_unused = ^tif.tz_offset;
  assign local_h   = tm.hh;
`endif

  assign tif.hours       = tm.hh;
  assign tif.minutes     = tm.mm;
  assign tif.seconds     = tm.ss;
  assign tif.local_hours = local_h;
  assign tif.sec_tick    = sec_tick_q;
  assign tif.day_wrap    = day_wrap_q;
  assign tif.edit_state  = state;

endmodule

// File: tb/tb_world_time_counter.sv
// Directed bench for world_time_counter: counting, carries, edit FSM, time zone, async reset.
module tb_world_time_counter;

  logic hz100 = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ticks = 0;
  int   wraps = 0;

`ifdef WORLD_TIME_TZ_EN
  localparam int EXP_M5  = 22;
  localparam int EXP_P14 = 17;
  localparam int EXP_M16 = 15;
  localparam int EXP_P15 = 17;
  localparam int EXP_M12 = 15;
`else
  localparam int EXP_M5  = 3;
  localparam int EXP_P14 = 3;
  localparam int EXP_M16 = 3;
  localparam int EXP_P15 = 3;
  localparam int EXP_M12 = 3;
`endif

  world_time_counter_if tif();

  world_time_counter #(.TICKS_PER_SEC(100)) dut (
    .hz100   (hz100),
    .reset_n (reset_n),
    .tif     (tif.slave)
  );

  always #5 hz100 = ~hz100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hms(input string tag, input int h, input int m, input int s);
    chk({tag, ".hours"}, 32'(tif.hours), 32'(h));
    chk({tag, ".minutes"}, 32'(tif.minutes), 32'(m));
    chk({tag, ".seconds"}, 32'(tif.seconds), 32'(s));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_hms(tag, 0, 0, 0);
    chk({tag, ".edit_state"}, 32'(tif.edit_state), 32'd0);
    chk({tag, ".sec_tick"}, 32'(tif.sec_tick), 32'd0);
    chk({tag, ".day_wrap"}, 32'(tif.day_wrap), 32'd0);
    chk({tag, ".local_hours"}, 32'(tif.local_hours), 32'd0);
  endtask

  // Advance n cycles, tallying pulses sampled at each falling edge.
  task automatic cnt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hz100);
      if (tif.sec_tick === 1'b1) ticks++;
      if (tif.day_wrap === 1'b1) wraps++;
    end
  endtask

  task automatic press_mode();
    tif.mode_btn = 1'b1;
    @(negedge hz100);
    tif.mode_btn = 1'b0;
    @(negedge hz100);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      tif.inc_btn = 1'b1;
      @(negedge hz100);
      tif.inc_btn = 1'b0;
      @(negedge hz100);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    tif.run       = 1'b1;
    tif.mode_btn  = 1'b1;
    tif.inc_btn   = 1'b0;
    tif.tz_offset = 5'd0;
    #12;
    chk_all_zero("reset");

    // Release with mode_btn still held: must not count as an edge.
    @(negedge hz100);
    reset_n = 1'b1;
    ticks = 0;
    cnt(50);
    tif.mode_btn = 1'b0;
    cnt(49);
    chk("first_sec.before", 32'(tif.seconds), 32'd0);
    chk("first_sec.no_early_tick", 32'(ticks), 32'd0);
    cnt(1);
    chk("first_sec.seconds", 32'(tif.seconds), 32'd1);
    chk("first_sec.sec_tick", 32'(tif.sec_tick), 32'd1);
    chk("first_sec.tick_count", 32'(ticks), 32'd1);
    chk("held_btn.no_edge", 32'(tif.edit_state), 32'd0);
    cnt(1);
    chk("first_sec.tick_one_cycle", 32'(tif.sec_tick), 32'd0);

    // run=0 freezes the prescaler at 1; resuming needs 99 more edges.
    tif.run = 1'b0;
    ticks = 0;
    cnt(150);
    chk("run0.seconds_held", 32'(tif.seconds), 32'd1);
    chk("run0.no_ticks", 32'(ticks), 32'd0);
    tif.run = 1'b1;
    cnt(98);
    chk("run0.resume_before", 32'(tif.seconds), 32'd1);
    cnt(1);
    chk("run0.resume_seconds", 32'(tif.seconds), 32'd2);
    chk("run0.resume_tick", 32'(tif.sec_tick), 32'd1);

    // mode, 5 inc, mode, 61 inc, mode.
    press_mode();
    chk("set.enter_hr", 32'(tif.edit_state), 32'd1);
    ticks = 0;
    cnt(200);
    chk("set_hr.seconds_held", 32'(tif.seconds), 32'd2);
    chk("set_hr.no_ticks", 32'(ticks), 32'd0);
    press_inc(5);
    chk("set_hr.hours5", 32'(tif.hours), 32'd5);
    press_mode();
    chk("set.enter_min", 32'(tif.edit_state), 32'd2);
    press_inc(61);
    chk_hms("set_min.61inc", 5, 1, 2);
    press_mode();
    chk("set.back_run", 32'(tif.edit_state), 32'd0);
    chk_hms("set.exit", 5, 1, 0);
    cnt(99);
    chk("exit.presc_cleared_before", 32'(tif.seconds), 32'd0);
    cnt(1);
    chk("exit.presc_cleared_after", 32'(tif.seconds), 32'd1);

    press_inc(3);
    chk_hms("run.inc_ignored", 5, 1, 1);

    // Coincident mode+inc in SET_HR: mode wins, inc dropped.
    press_mode();
    tif.mode_btn = 1'b1;
    tif.inc_btn  = 1'b1;
    @(negedge hz100);
    tif.mode_btn = 1'b0;
    tif.inc_btn  = 1'b0;
    @(negedge hz100);
    chk("coincide.state", 32'(tif.edit_state), 32'd2);
    chk("coincide.hours", 32'(tif.hours), 32'd5);
    chk("coincide.minutes", 32'(tif.minutes), 32'd1);
    press_mode();

    // Preload 23:59 then tick up to 23:59:59.
    press_mode();
    press_inc(19);
    chk("hr_mod24.wrap", 32'(tif.hours), 32'd0);
    press_inc(23);
    chk("hr_mod24.23", 32'(tif.hours), 32'd23);
    press_mode();
    press_inc(58);
    chk("min.59", 32'(tif.minutes), 32'd59);
    press_mode();
    ticks = 0;
    wraps = 0;
    cnt(5900);
    chk_hms("preload", 23, 59, 59);
    chk("preload.ticks", 32'(ticks), 32'd59);
    chk("preload.no_day_wrap", 32'(wraps), 32'd0);
    ticks = 0;
    cnt(99);
    chk("daywrap.before", 32'(tif.seconds), 32'd59);
    chk("daywrap.no_tick_before", 32'(ticks), 32'd0);
    cnt(1);
    chk_hms("daywrap", 0, 0, 0);
    chk("daywrap.day_wrap", 32'(tif.day_wrap), 32'd1);
    chk("daywrap.sec_tick", 32'(tif.sec_tick), 32'd1);
    cnt(1);
    chk("daywrap.pulse_end", 32'(tif.day_wrap), 32'd0);
    chk("daywrap.tick_end", 32'(tif.sec_tick), 32'd0);

    // Mode edge lands on the prescaler-wrap edge: increment still applies.
    cnt(97);
    press_mode();
    chk("wrap_mode.state", 32'(tif.edit_state), 32'd1);
    chk("wrap_mode.seconds", 32'(tif.seconds), 32'd1);
    chk("wrap_mode.sec_tick", 32'(tif.sec_tick), 32'd1);
    ticks = 0;
    cnt(150);
    chk("wrap_mode.frozen", 32'(tif.seconds), 32'd1);
    chk("wrap_mode.no_ticks", 32'(ticks), 32'd0);

    // Time-zone view at hours = 3.
    press_inc(3);
    chk("tz.hours3", 32'(tif.hours), 32'd3);
    tif.tz_offset = 5'b11011;
    #1 chk("tz.minus5", 32'(tif.local_hours), 32'(EXP_M5));
    tif.tz_offset = 5'b01110;
    #1 chk("tz.plus14", 32'(tif.local_hours), 32'(EXP_P14));
    tif.tz_offset = 5'b10000;
    #1 chk("tz.minus16_clamp", 32'(tif.local_hours), 32'(EXP_M16));
    tif.tz_offset = 5'b01111;
    #1 chk("tz.plus15_clamp", 32'(tif.local_hours), 32'(EXP_P15));
    tif.tz_offset = 5'b10100;
    #1 chk("tz.minus12", 32'(tif.local_hours), 32'(EXP_M12));
    tif.tz_offset = 5'd0;
    #1 chk("tz.zero", 32'(tif.local_hours), 32'd3);
    @(negedge hz100);

    // Reach 12:34:56 and reset asynchronously between clock edges.
    press_inc(9);
    press_mode();
    press_inc(34);
    press_mode();
    cnt(5600);
    chk_hms("pre_reset", 12, 34, 56);
    cnt(37);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge hz100);
    reset_n = 1'b1;
    cnt(99);
    chk_hms("restart.before", 0, 0, 0);
    cnt(1);
    chk_hms("restart.first_sec", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
